rx_iq_scheduler: RTL
====================

Name: rx_iq_scheduler

Overview:
Arbitrates RX1 and RX2 DDC sample pairs into one tagged sample FIFO, then serialises FIFO entries byte-by-byte for the STM32 parallel-bus RX IQ transfer. It sits between the two DDC output stages and the bus interface's RX IQ read path. RX2 samples are no longer lost when the bus is slow; overflow is reported to the MCU.

Parameters:
FIFO_DEPTH, 8, tagged-sample entries; power of two, minimum 2
IQ_W, 32, width of each signed I or Q sample

Ports:
clk_in  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
rx1_en  in  1  RX1 capture enable
rx2_en  in  1  RX2 capture enable
RX1_I  in  IQ_W  RX1 I sample
RX1_Q  in  IQ_W  RX1 Q sample
RX1_valid  in  1  one-cycle strobe; RX1_I/Q valid
RX2_I  in  IQ_W  RX2 I sample
RX2_Q  in  IQ_W  RX2 Q sample
RX2_valid  in  1  one-cycle strobe; RX2_I/Q valid
rd_start  in  1  bus requests start of RX IQ stream
rd_next  in  1  bus consumed current rd_byte; advance
rd_stop  in  1  bus ends stream; return to IDLE
rd_byte  out  8  current output byte
rd_avail  out  1  FIFO not empty
fill_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy
overrun  out  1  sticky sample-drop flag
overrun_clr  in  1  clears overrun

Behaviour:
- Reset: FIFO and skid register emptied. rd_byte=0x00, rd_avail=0, fill_level=0, overrun=0, FSM in IDLE, byte_idx=0. Reset mid-frame aborts the frame; the next byte after reset is 0x00.
- Entry format: {tag[1:0], Q, I}. tag 2'b01 = RX1, 2'b10 = RX2.
- Write side: at most one FIFO write per cycle.
  - Valid strobes are ignored when their channel enable is 0.
  - Priority order: RX1 valid first, then a pending RX2 skid entry, then a live RX2 valid.
  - RX2 valid that cannot be written this cycle goes to a 1-deep skid register.
  - RX2 valid while skid is occupied and the skid is not drained this cycle: drop the new sample, set overrun.
- Full rule: a write is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the candidate sample is dropped and overrun is set. A dropped RX2 candidate that came from the skid is discarded.
- overrun: overrun_clr clears it. If a set and overrun_clr occur in the same cycle, set wins.
- fill_level updates one cycle after the write or pop. rd_avail = (fill_level != 0).
- Read FSM states: IDLE, SEND.
  - IDLE with rd_start and FIFO non-empty: pop the head entry into a 72-bit shift register, go to SEND, byte_idx=0. rd_byte is valid on the next cycle (latency 1).
  - IDLE with rd_start and FIFO empty: rd_byte=0x00, stay in IDLE.
  - SEND byte order: idx0 = tag byte (0x01 or 0x02), idx1–4 = Q[31:24]..Q[7:0], idx5–8 = I[31:24]..I[7:0]. Each frame is 9 bytes.
  - rd_next in SEND with byte_idx<8: increment byte_idx.
  - rd_next at byte_idx=8 with FIFO non-empty: pop the next entry, byte_idx=0, stay in SEND (continuous streaming).
  - rd_next at byte_idx=8 with FIFO empty: go to IDLE, rd_byte=0x00.
  - rd_start while in SEND is ignored.
  - rd_stop in any state: go to IDLE next cycle. A partially sent entry is discarded; it is not re-queued.
  - If rd_stop and rd_next arrive together, rd_stop wins.
- Disabling a channel does not flush its entries already in the FIFO. A pending skid entry is discarded when rx2_en=0.

Decomposition:
- Package rx_iq_pkg holds:
  - TAG_RX1 = 2'b01, TAG_RX2 = 2'b10
  - BYTE_EMPTY = 8'h00
  - FRAME_BYTES = 9
  - the read-FSM state enum
- Sub-module iq_sample_fifo: synchronous FIFO, width 2+2*IQ_W, depth FIFO_DEPTH.
  - Signals: wr_en, rd_en, full, empty, count.
  - Read data is registered, one-cycle latency.
  - Simultaneous read and write when full is allowed.

Test Plan:
- Single RX1 sample, RX1_Q=0x11223344, RX1_I=0x55667788; rd_start then 8× rd_next -> rd_byte sequence 01 11 22 33 44 55 66 77 88, then 00; FSM returns to IDLE.
- RX1_valid and RX2_valid in the same cycle, both enabled -> two frames in order, tags 01 then 02. Second RX2 valid on the next cycle -> skid used, no overrun, fill_level=3.
- Fill with 8 RX1 samples and no reads, then a 9th valid -> fill_level stays 8, overrun=1. overrun_clr -> overrun=0. 9th valid coincident with a pop -> accepted, overrun stays 0.
- rx2_en=0 with RX2_valid pulses -> FIFO unchanged, no overrun. rd_start on empty FIFO -> rd_byte=00, rd_avail=0.
- Continuous stream of 3 queued entries, rd_next every cycle -> 27 contiguous bytes with no gap, then 00. rd_stop at byte_idx=4 of entry 2 -> IDLE; entry 3 remains, fill_level=1.
- reset asserted mid-frame with fill_level=5 -> next cycle rd_byte=00, fill_level=0, overrun=0, FSM in IDLE.

Source files
------------

// File: rtl/rx_iq_pkg.sv
// Shared tags, byte constants and read-FSM state type for the RX IQ scheduler.
package rx_iq_pkg;

  localparam logic [1:0] TAG_RX1     = 2'b01;
  localparam logic [1:0] TAG_RX2     = 2'b10;
  localparam logic [7:0] BYTE_EMPTY  = 8'h00;
  localparam int         FRAME_BYTES = 9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } rd_state_e;

endpackage

// File: rtl/iq_sample_fifo.sv
// Synchronous tagged-sample FIFO with registered read data.
// A write into a full FIFO is accepted when a read happens on the same edge.
module iq_sample_fifo #(
  parameter int WIDTH = 66,
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage and read register carry data only; no reset needed.
  always_ff @(posedge clk_in) begin
    if (do_wr) mem[wptr] <= wr_data;
    if (do_rd) rd_data <= mem[rptr];
  end

endmodule

// File: rtl/rx_iq_scheduler.sv
// Merges RX1/RX2 DDC sample pairs into one tagged FIFO (RX2 backed by a skid slot)
// and streams each entry as a 9-byte frame to the MCU parallel-bus read path.
module rx_iq_scheduler
  import rx_iq_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int IQ_W       = 32
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          rx1_en,
  input  logic                          rx2_en,
  input  logic signed [IQ_W-1:0]        RX1_I,
  input  logic signed [IQ_W-1:0]        RX1_Q,
  input  logic                          RX1_valid,
  input  logic signed [IQ_W-1:0]        RX2_I,
  input  logic signed [IQ_W-1:0]        RX2_Q,
  input  logic                          RX2_valid,
  input  logic                          rd_start,
  input  logic                          rd_next,
  input  logic                          rd_stop,
  output logic [7:0]                    rd_byte,
  output logic                          rd_avail,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overrun,
  input  logic                          overrun_clr
);

  localparam int         EW   = 2 + 2*IQ_W;
  localparam int         FW   = 8*FRAME_BYTES;
  localparam logic [3:0] LAST = 4'(FRAME_BYTES-1);

  logic          v1, v2, skid_live;
  logic          skid_vld;
  logic [EW-1:0] skid_data;
  logic [EW-1:0] cand;
  logic          has_cand, can_wr, wr_en, cand_drop;
  logic          skid_drain, v2_lost, skid_free, skid_load, skid_drop;
  logic          pop, full, empty;
  logic [EW-1:0] head;
  logic [FW-1:0] frame;
  logic [7:0]    byte_sel;
  logic [3:0]    byte_idx, idx_nxt;
  rd_state_e     state, state_nxt;

  assign v1        = RX1_valid & rx1_en;
  assign v2        = RX2_valid & rx2_en;
  assign skid_live = skid_vld & rx2_en;

  // Arbitration: RX1, then the parked RX2 sample, then live RX2.
  always_comb begin
    cand     = '0;
    has_cand = 1'b0;
    if (v1) begin
      cand     = {TAG_RX1, RX1_Q, RX1_I};
      has_cand = 1'b1;
    end else if (skid_live) begin
      cand     = skid_data;
      has_cand = 1'b1;
    end else if (v2) begin
      cand     = {TAG_RX2, RX2_Q, RX2_I};
      has_cand = 1'b1;
    end
  end

  assign can_wr     = ~full | pop;
  assign wr_en      = has_cand & can_wr;
  assign cand_drop  = has_cand & ~can_wr;
  assign skid_drain = skid_live & ~v1;
  assign v2_lost    = v2 & (v1 | skid_live);
  assign skid_free  = ~skid_live | skid_drain;
  assign skid_load  = v2_lost & skid_free;
  assign skid_drop  = v2_lost & ~skid_free;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      skid_vld <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (skid_load) skid_vld <= 1'b1;
      else if (skid_drain || !rx2_en) skid_vld <= 1'b0;
      if (cand_drop || skid_drop) overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (skid_load) skid_data <= {TAG_RX2, RX2_Q, RX2_I};
  end

  iq_sample_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_in  (clk_in),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (cand),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .count   (fill_level)
  );

  assign rd_avail = (fill_level != '0);

  // Read FSM: the FIFO read register doubles as the frame holding register.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state    <= ST_IDLE;
      byte_idx <= '0;
    end else begin
      state    <= state_nxt;
      byte_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = byte_idx;
    case (state)
      ST_IDLE: begin
        if (pop) begin
          state_nxt = ST_SEND;
          idx_nxt   = '0;
        end
      end
      ST_SEND: begin
        if (rd_stop) begin
          state_nxt = ST_IDLE;
          idx_nxt   = '0;
        end else if (rd_next) begin
          if (byte_idx != LAST) begin
            idx_nxt = byte_idx + 4'd1;
          end else if (pop) begin
            idx_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign frame = FW'(head);

  always_comb begin
    pop      = 1'b0;
    byte_sel = BYTE_EMPTY;
    case (state)
      ST_IDLE: pop = rd_start & ~rd_stop & ~empty;
      ST_SEND: pop = rd_next & ~rd_stop & (byte_idx == LAST) & ~empty;
      default: pop = 1'b0;
    endcase
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (byte_idx == 4'(k)) byte_sel = frame[FW-1-8*k -: 8];
    end
    rd_byte = (state == ST_SEND) ? byte_sel : BYTE_EMPTY;
  end

endmodule
